// File: rtl/octa16_pkg.sv
// Shared types and default sizes for the octa16 memory arbiter.
package octa16_pkg;
  localparam int AW_DEF           = 16;
  localparam int DW_DEF           = 16;
  localparam int STARVE_LIMIT_DEF = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_IF = 2'd1,
    BUSY_D  = 2'd2
  } state_t;
endpackage

// File: rtl/arb_select.sv
// Winner select between fetch and data ports; data has fixed priority.
// Optional fetch starvation guard is enabled by macro FETCH_STARVE_GUARD_EN.
module arb_select
  import octa16_pkg::*;
#(
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic arb_en,
  input  logic if_req,
  input  logic d_req,
  output logic pick_if,
  output logic pick_d
);

`ifdef FETCH_STARVE_GUARD_EN
  localparam int CW = $clog2(STARVE_LIMIT + 1);

  logic [CW-1:0] starve_cnt;
  logic          fetch_due;

  assign fetch_due = (starve_cnt == CW'(STARVE_LIMIT));

  always_comb begin
    pick_if = arb_en & if_req & (~d_req | fetch_due);
    pick_d  = arb_en & d_req & ~pick_if;
  end

  // Counter only moves on arbitration cycles; at the limit fetch wins, so it never overflows.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= '0;
    end else if (arb_en) begin
      if (pick_if || !if_req) begin
        starve_cnt <= '0;
      end else if (pick_d) begin
        starve_cnt <= starve_cnt + 1'b1;
      end
    end
  end
`else
  localparam int unused_limit = STARVE_LIMIT;
  logic unused_ok;

  assign unused_ok = ^{clk, rst_n};

  always_comb begin
    pick_d  = arb_en & d_req;
    pick_if = arb_en & if_req & ~d_req;
  end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Two-port (fetch/data) single-memory arbiter with a three-state FSM.
// Optional fetch starvation guard: define FETCH_STARVE_GUARD_EN.
module mem_arbiter
  import octa16_pkg::*;
#(
  parameter int AW           = AW_DEF,
  parameter int DW           = DW_DEF,
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_gnt,
  output logic          if_rvalid,
  output logic [DW-1:0] if_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_gnt,
  output logic          d_rvalid,
  output logic [DW-1:0] d_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ready
);

  // Handshake: a requester holds req until it sees gnt (one-cycle pulse in the
  // first BUSY cycle); the matching rvalid pulses once in the following IDLE cycle.

  state_t        state;
  state_t        state_nxt;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic          we_q;
  logic          arb_en;
  logic          pick_if;
  logic          pick_d;

  assign arb_en = (state == IDLE);

  arb_select #(
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_arb_select (
    .clk     (clk),
    .rst_n   (rst_n),
    .arb_en  (arb_en),
    .if_req  (if_req),
    .d_req   (d_req),
    .pick_if (pick_if),
    .pick_d  (pick_d)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (pick_d) begin
          state_nxt = BUSY_D;
        end else if (pick_if) begin
          state_nxt = BUSY_IF;
        end
      end
      BUSY_IF, BUSY_D: begin
        if (mem_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q    <= '0;
      wdata_q   <= '0;
      we_q      <= 1'b0;
      if_gnt    <= 1'b0;
      d_gnt     <= 1'b0;
      if_rvalid <= 1'b0;
      d_rvalid  <= 1'b0;
      if_rdata  <= '0;
      d_rdata   <= '0;
    end else begin
      if_gnt    <= 1'b0;
      d_gnt     <= 1'b0;
      if_rvalid <= 1'b0;
      d_rvalid  <= 1'b0;
      if (pick_d) begin
        addr_q  <= d_addr;
        we_q    <= d_we;
        wdata_q <= d_wdata;
        d_gnt   <= 1'b1;
      end else if (pick_if) begin
        addr_q  <= if_addr;
        we_q    <= 1'b0;
        wdata_q <= '0;
        if_gnt  <= 1'b1;
      end
      if (state == BUSY_IF && mem_ready) begin
        if_rdata  <= mem_rdata;
        if_rvalid <= 1'b1;
      end
      // Writes complete with an acknowledge only; read data register is left alone.
      if (state == BUSY_D && mem_ready) begin
        d_rvalid <= 1'b1;
        if (!we_q) begin
          d_rdata <= mem_rdata;
        end
      end
    end
  end

  assign mem_en    = (state != IDLE);
  assign mem_we    = (state == BUSY_D) & we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;

endmodule
